// File: rtl/pe_frame_sequencer.sv
// Frame sequencer for the background-removal PE: a sum pass then a removal pass over the frame buffer.
// Optional PE watchdog enabled by defining PE_TIMEOUT_EN.
module pe_frame_sequencer #(
    parameter int NUM_PIXELS = 25,
    parameter int ADDR_W     = 5,
    parameter int TIMEOUT    = 64
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Go,
    input  logic              Ack,
    output logic              Busy,
    output logic              Done,
    output logic              Err,
    output logic [3:0]        state,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [23:0]       mem_rd_data,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [23:0]       mem_wr_data,
    output logic [7:0]        pe_red_in,
    output logic [7:0]        pe_green_in,
    output logic [7:0]        pe_blue_in,
    output logic              pe_start_sum,
    output logic              pe_start_bg,
    output logic              pe_ack,
    input  logic              pe_done,
    input  logic [7:0]        pe_red_out,
    input  logic [7:0]        pe_green_out,
    input  logic [7:0]        pe_blue_out
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_SUM_RD    = 4'd1,
        S_SUM_ISSUE = 4'd2,
        S_SUM_WAIT  = 4'd3,
        S_BG_RD     = 4'd4,
        S_BG_ISSUE  = 4'd5,
        S_BG_WAIT   = 4'd6,
        S_DONE      = 4'd7,
        S_ERR       = 4'd8
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PIXELS - 1);

    state_t            state_r;
    logic [ADDR_W-1:0] idx_r;

`ifdef PE_TIMEOUT_EN
    localparam int          CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0] wait_cnt_r;
`else
    logic [31:0] unused_timeout_s;
    assign unused_timeout_s = 32'(TIMEOUT);
    assign Err = 1'b0;
`endif

    assign state = state_r;

    // Frame FSM: every output is a register updated here; pulses default low each cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r      <= S_IDLE;
            idx_r        <= '0;
            Busy         <= 1'b0;
            Done         <= 1'b0;
            mem_rd_en    <= 1'b0;
            mem_rd_addr  <= '0;
            mem_wr_en    <= 1'b0;
            mem_wr_addr  <= '0;
            mem_wr_data  <= 24'h000000;
            pe_red_in    <= 8'h00;
            pe_green_in  <= 8'h00;
            pe_blue_in   <= 8'h00;
            pe_start_sum <= 1'b0;
            pe_start_bg  <= 1'b0;
            pe_ack       <= 1'b0;
`ifdef PE_TIMEOUT_EN
            Err          <= 1'b0;
            wait_cnt_r   <= '0;
`endif
        end else begin
            mem_rd_en    <= 1'b0;
            mem_wr_en    <= 1'b0;
            pe_start_sum <= 1'b0;
            pe_start_bg  <= 1'b0;
            pe_ack       <= 1'b0;

            case (state_r)
                S_IDLE: begin
                    if (Go) begin
                        state_r     <= S_SUM_RD;
                        idx_r       <= '0;
                        Busy        <= 1'b1;
                        mem_rd_en   <= 1'b1;
                        mem_rd_addr <= '0;
                    end else begin
                        state_r     <= S_IDLE;
                    end
                end

                // The start pulse is raised on leaving RD so that it coincides with the ISSUE cycle.
                S_SUM_RD, S_BG_RD: begin
                    state_r      <= (state_r == S_SUM_RD) ? S_SUM_ISSUE : S_BG_ISSUE;
                    pe_start_sum <= (state_r == S_SUM_RD);
                    pe_start_bg  <= (state_r == S_BG_RD);
                end

                S_SUM_ISSUE, S_BG_ISSUE: begin
                    pe_red_in   <= mem_rd_data[23:16];
                    pe_green_in <= mem_rd_data[15:8];
                    pe_blue_in  <= mem_rd_data[7:0];
                    state_r     <= (state_r == S_SUM_ISSUE) ? S_SUM_WAIT : S_BG_WAIT;
`ifdef PE_TIMEOUT_EN
                    wait_cnt_r  <= '0;
`endif
                end

                S_SUM_WAIT, S_BG_WAIT: begin
                    if (pe_done) begin
                        pe_ack <= 1'b1;
                        if (state_r == S_BG_WAIT) begin
                            mem_wr_en   <= 1'b1;
                            mem_wr_addr <= idx_r;
                            mem_wr_data <= {pe_red_out, pe_green_out, pe_blue_out};
                        end
                        // The ack cycle doubles as the next read cycle, so no bubble between pixels.
                        if (idx_r == LAST_IDX) begin
                            idx_r <= '0;
                            if (state_r == S_SUM_WAIT) begin
                                state_r     <= S_BG_RD;
                                mem_rd_en   <= 1'b1;
                                mem_rd_addr <= '0;
                            end else begin
                                state_r     <= S_DONE;
                                Busy        <= 1'b0;
                                Done        <= 1'b1;
                            end
                        end else begin
                            idx_r       <= idx_r + ADDR_W'(1);
                            state_r     <= (state_r == S_SUM_WAIT) ? S_SUM_RD : S_BG_RD;
                            mem_rd_en   <= 1'b1;
                            mem_rd_addr <= idx_r + ADDR_W'(1);
                        end
                    end
`ifdef PE_TIMEOUT_EN
                    else if (wait_cnt_r == CNT_MAX) begin
                        state_r <= S_ERR;
                        Err     <= 1'b1;
                        pe_ack  <= 1'b1;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + CNT_W'(1);
                    end
`endif
                end

                S_DONE: begin
                    if (Ack) begin
                        state_r <= S_IDLE;
                        Done    <= 1'b0;
                    end else begin
                        state_r <= S_DONE;
                    end
                end

`ifdef PE_TIMEOUT_EN
                S_ERR: begin
                    if (Ack) begin
                        state_r <= S_IDLE;
                        Err     <= 1'b0;
                        Busy    <= 1'b0;
                    end else begin
                        state_r <= S_ERR;
                    end
                end
`endif

                default: begin
                    state_r <= S_IDLE;
                    idx_r   <= '0;
                    Busy    <= 1'b0;
                    Done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
